serial_paralelo_phy_tx: RTL and testbench

- Transmit-side PHY serializer.
- Converts a byte stream into one serial bit per clk_32f cycle, MSB first.
- After reset, sends N_SYNC comma words (0xBC) so the far-end receiver can lock and go active. Then sends accepted data bytes, and inserts the comma as idle fill whenever no byte is offered.
- Sits between the link-layer byte source and the serial lane.

---
 rtl/serial_paralelo_phy_tx.sv | 91 +++++++++
 tb/tb_serial_paralelo_phy_tx.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/serial_paralelo_phy_tx.sv
// rtl/serial_paralelo_phy_tx.sv - byte-to-serial PHY transmitter, MSB first
// Sends a comma preamble after reset, then data bytes with comma idle fill.
module serial_paralelo_phy_tx #(
  parameter int unsigned N_SYNC = 4,
  parameter logic [7:0]  COMMA  = 8'hBC
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready,
  output logic       data_out,
  output logic       tx_active,
  output logic       word_start,
  output logic       is_data
);

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] sync_cnt_q, sync_cnt_d;
  logic       data_out_q, data_out_d;
  logic       tx_active_q, tx_active_d;
  logic       word_start_q, word_start_d;
  logic       is_data_q, is_data_d;
  logic [7:0] word;

  assign ready      = (state_q == ST_RUN) && (bit_cnt_q == 3'd0) && reset_L;
  assign data_out   = data_out_q;
  assign tx_active  = tx_active_q;
  assign word_start = word_start_q;
  assign is_data    = is_data_q;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q + 3'd1;
    shift_d      = {shift_q[6:0], 1'b0};
    sync_cnt_d   = sync_cnt_q;
    data_out_d   = shift_q[7];
    tx_active_d  = tx_active_q;
    word_start_d = 1'b0;
    is_data_d    = is_data_q;
    word         = COMMA;

    if (bit_cnt_q == 3'd0) begin
      is_data_d = 1'b0;
      if (state_q == ST_SYNC) begin
        sync_cnt_d = sync_cnt_q + 4'd1;
        // The last preamble comma also opens the link for the next slot.
        if (sync_cnt_q == 4'(N_SYNC - 1)) begin
          state_d     = ST_RUN;
          tx_active_d = 1'b1;
        end
      end else if (valid_in) begin
        word      = data_in;
        is_data_d = 1'b1;
      end
      data_out_d   = word[7];
      shift_d      = {word[6:0], 1'b0};
      word_start_d = 1'b1;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      state_q      <= ST_SYNC;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      sync_cnt_q   <= 4'd0;
      data_out_q   <= 1'b0;
      tx_active_q  <= 1'b0;
      word_start_q <= 1'b0;
      is_data_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      sync_cnt_q   <= sync_cnt_d;
      data_out_q   <= data_out_d;
      tx_active_q  <= tx_active_d;
      word_start_q <= word_start_d;
      is_data_q    <= is_data_d;
    end
  end

endmodule

// File: tb/tb_serial_paralelo_phy_tx.sv
// tb/tb_serial_paralelo_phy_tx.sv - randomized bench for serial_paralelo_phy_tx
// Slot-level reference model plus a byte scoreboard recovered from the serial lane.
module tb_serial_paralelo_phy_tx;

  localparam int         N_SYNC = 4;
  localparam logic [7:0] COMMA  = 8'hBC;

  logic       clk_32f  = 1'b0;
  logic       reset_L  = 1'b0;
  logic [7:0] data_in  = 8'd0;
  logic       valid_in = 1'b0;
  logic       ready, data_out, tx_active, word_start, is_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_32f = ~clk_32f;

  serial_paralelo_phy_tx #(.N_SYNC(N_SYNC), .COMMA(COMMA)) dut (
    .clk_32f    (clk_32f),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready      (ready),
    .data_out   (data_out),
    .tx_active  (tx_active),
    .word_start (word_start),
    .is_data    (is_data)
  );

  // Model state: p counts edges since the last reset edge; each slot is 8 edges.
  int         p = 0;
  logic [7:0] m_word = 8'd0;
  logic       m_isd = 1'b0;
  logic       e_dout = 1'b0, e_ws = 1'b0, e_isd = 1'b0, e_act = 1'b0;

  logic [7:0] src_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] rx_q[$];
  logic       pending = 1'b0;
  logic [7:0] pend_byte = 8'd0;
  bit         eager = 1'b0;
  logic [7:0] rx_sh = 8'd0;
  int         rx_n = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, p);
  endtask

  // One clock: drive inputs at negedge, predict, clock, then compare at next negedge.
  task automatic cycle(input logic rst_n_i);
    int   b;
    logic exp_ready;
    reset_L = rst_n_i;
    if (!pending && src_q.size() > 0 && (eager || $urandom_range(0, 2) != 0)) begin
      pending   = 1'b1;
      pend_byte = src_q.pop_front();
    end
    valid_in = pending && (eager || $urandom_range(0, 3) != 0);
    data_in  = pending ? pend_byte : 8'($urandom);
    #1;
    exp_ready = rst_n_i && (p % 8 == 0) && (p / 8 >= N_SYNC);
    check("ready", 32'(ready), 32'(exp_ready));

    if (!rst_n_i) begin
      if (m_isd && (p % 8 != 0)) void'(sent_q.pop_back());
      p = 0; m_isd = 1'b0; m_word = 8'd0;
      e_dout = 1'b0; e_ws = 1'b0; e_isd = 1'b0; e_act = 1'b0;
    end else begin
      b = p % 8;
      if (b == 0) begin
        if (p / 8 >= N_SYNC && valid_in) begin
          m_word = pend_byte; m_isd = 1'b1;
          sent_q.push_back(pend_byte);
          pending = 1'b0;
        end else begin
          m_word = COMMA; m_isd = 1'b0;
        end
      end
      e_dout = m_word[7 - b];
      e_ws   = (b == 0);
      e_isd  = m_isd;
      e_act  = (p / 8 >= N_SYNC - 1);
      p++;
    end

    @(posedge clk_32f);
    @(negedge clk_32f);
    check("outs{dout,ws,isd,act}", 32'({data_out, word_start, is_data, tx_active}),
          32'({e_dout, e_ws, e_isd, e_act}));

    if (!reset_L) rx_n = 0;
    else if (is_data) begin
      if (word_start) rx_n = 0;
      rx_sh = {rx_sh[6:0], data_out};
      rx_n++;
      if (rx_n == 8) begin
        rx_q.push_back(rx_sh);
        rx_n = 0;
      end
    end
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] v;
    v = 8'($urandom);
    if (v == COMMA) v = 8'h00;
    return v;
  endfunction

  initial begin
    int budget;
    @(negedge clk_32f);
    repeat (3) cycle(1'b0);

    // Preamble with no traffic, then a byte offered during SYNC.
    repeat (10) cycle(1'b1);
    src_q.push_back(8'h55);
    repeat (40) cycle(1'b1);

    src_q.push_back(8'hA5);
    repeat (30) cycle(1'b1);

    eager = 1'b1;
    src_q.push_back(8'h00); src_q.push_back(8'hFF); src_q.push_back(8'h3C);
    repeat (40) cycle(1'b1);
    eager = 1'b0;

    // Reset pulse in the middle of a data word, byte held across the reset.
    src_q.push_back(8'h81);
    budget = 0;
    while (!(m_isd && p % 8 == 3) && budget < 200) begin
      cycle(1'b1);
      budget++;
    end
    check("reach_mid_word", 32'(budget < 200), 32'd1);
    src_q.push_back(8'h42);
    cycle(1'b0);
    repeat (50) cycle(1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 200; i++) src_q.push_back(rand_byte());
    budget = 0;
    while ((src_q.size() > 0 || pending) && budget < 20000) begin
      cycle($urandom_range(0, 499) != 0);
      budget++;
    end
    check("drain_done", 32'(budget < 20000), 32'd1);
    repeat (16) cycle(1'b1);

    check("rx_count", 32'(rx_q.size()), 32'(sent_q.size()));
    for (int i = 0; i < sent_q.size() && i < rx_q.size(); i++)
      check("rx_byte", 32'(rx_q[i]), 32'(sent_q[i]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
